// File: rtl/fpga_pin_sampler_pkg.sv
// fpga_pin_sampler_pkg
// Shared constants and types for the pin sampler:
//   NUM_PINS  - number of sampled external pins
//   CNT_W     - width of each pin's debounce tick counter
//   state_t   - reporting FSM encoding
package fpga_pin_sampler_pkg;

    localparam int NUM_PINS = 16;
    localparam int CNT_W    = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

endpackage

// File: rtl/fpga_pin_sampler_if.sv
// fpga_pin_sampler_if
// Report channel between the sampler and its consumer.
//   ev_valid   - report available (sampler -> consumer)
//   ev_ready   - consumer accepts the report (consumer -> sampler)
//   ev_state   - debounced pin levels at report time
//   ev_changed - pins whose debounced level changed since the last accepted report
//   ev_overrun - sticky flag: some pin changed twice before being reported
//   ev_clear   - synchronous clear of ev_overrun (consumer -> sampler)
// Modports: master = sampler side, slave = consumer side.
interface fpga_pin_sampler_if;
    import fpga_pin_sampler_pkg::*;

    logic                ev_valid;
    logic                ev_ready;
    logic [NUM_PINS-1:0] ev_state;
    logic [NUM_PINS-1:0] ev_changed;
    logic                ev_overrun;
    logic                ev_clear;

    modport master (
        output ev_valid, ev_state, ev_changed, ev_overrun,
        input  ev_ready, ev_clear
    );

    modport slave (
        input  ev_valid, ev_state, ev_changed, ev_overrun,
        output ev_ready, ev_clear
    );
endinterface

// File: rtl/fpga_pin_sampler_pin_debounce.sv
// pin_debounce
// One pin's path: 2-flop synchronizer, tick-driven debounce counter and
// debounced level, plus a one-cycle pulse when the debounced level flips.
//   clk, rst_n - clock, asynchronous active-low reset
//   pin        - raw asynchronous pin
//   tick       - sample strobe from the shared prescaler
//   stable     - debounced level
//   pulse      - high for the single cycle in which stable takes a new value
module pin_debounce
    import fpga_pin_sampler_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic tick,
    output logic stable,
    output logic pulse
);

    logic             sync1;
    logic             synced;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            synced <= 1'b0;
        end else begin
            sync1  <= pin;
            synced <= sync1;
        end
    end

    // The counter only advances on ticks where the synced level disagrees
    // with the accepted level; any agreeing tick (a bounce back) restarts it.
    // Reaching DEBOUNCE_COUNT flips stable and raises pulse on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (tick) begin
                if (synced != stable) begin
                    if (cnt == CNT_W'(DEBOUNCE_COUNT - 1)) begin
                        stable <= synced;
                        cnt    <= '0;
                        pulse  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/fpga_pin_sampler.sv
// fpga_pin_sampler
// Samples 16 asynchronous pins, debounces each one and reports debounced
// level changes over a valid/ready channel, merging changes that arrive
// while a report is outstanding.
//   clk, rst_n   - clock, asynchronous active-low reset
//   pin0..pin15  - raw external pins (pinN -> bit N of ev_state/ev_changed)
//   ev           - report channel (master side), see fpga_pin_sampler_if
module fpga_pin_sampler
    import fpga_pin_sampler_pkg::*;
#(
    parameter int SAMPLE_DIV     = 1000,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin0,
    input  logic pin1,
    input  logic pin2,
    input  logic pin3,
    input  logic pin4,
    input  logic pin5,
    input  logic pin6,
    input  logic pin7,
    input  logic pin8,
    input  logic pin9,
    input  logic pin10,
    input  logic pin11,
    input  logic pin12,
    input  logic pin13,
    input  logic pin14,
    input  logic pin15,
    fpga_pin_sampler_if.master ev
);

    localparam int PW = $clog2(SAMPLE_DIV);

    logic [NUM_PINS-1:0] pin_vec;
    logic [NUM_PINS-1:0] stable_vec;
    logic [NUM_PINS-1:0] pulse_vec;

    logic [PW-1:0]       presc_q;
    logic                tick;

    state_t              state_q,   state_d;
    logic                valid_q,   valid_d;
    logic [NUM_PINS-1:0] st_q,      st_d;
    logic [NUM_PINS-1:0] chg_q,     chg_d;
    logic [NUM_PINS-1:0] pend_q,    pend_d;
    logic                ovr_q,     ovr_d;
    logic [NUM_PINS-1:0] merged;
    logic                ovr_set;

    assign pin_vec = {pin15, pin14, pin13, pin12, pin11, pin10, pin9, pin8,
                      pin7,  pin6,  pin5,  pin4,  pin3,  pin2,  pin1, pin0};

    // tick is decoded from the prescaler value itself, so it is high for
    // exactly the one cycle spent at SAMPLE_DIV-1.
    assign tick = (presc_q == PW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        pin_debounce #(
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
        ) u_pin_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin    (pin_vec[i]),
            .tick   (tick),
            .stable (stable_vec[i]),
            .pulse  (pulse_vec[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            st_q    <= '0;
            chg_q   <= '0;
            pend_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            st_q    <= st_d;
            chg_q   <= chg_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    // Pulses are registered alongside stable, so stable_vec already holds
    // the new levels in the cycle a pulse is visible here. On acceptance the
    // same-cycle pulses are folded into the next report rather than dropped.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        st_d    = st_q;
        chg_d   = chg_q;
        pend_d  = pend_q;
        merged  = pend_q | pulse_vec;
        ovr_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|pulse_vec) begin
                    valid_d = 1'b1;
                    st_d    = stable_vec;
                    chg_d   = pulse_vec;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                ovr_set = |(pulse_vec & (chg_q | pend_q));
                if (ev.ev_ready) begin
                    if (|merged) begin
                        st_d   = stable_vec;
                        chg_d  = merged;
                        pend_d = '0;
                    end else begin
                        valid_d = 1'b0;
                        chg_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    pend_d = merged;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ovr_d = ovr_set | (ovr_q & ~ev.ev_clear);
    end

    assign ev.ev_valid   = valid_q;
    assign ev.ev_state   = st_q;
    assign ev.ev_changed = chg_q;
    assign ev.ev_overrun = ovr_q;

endmodule

// File: doc/fpga_pin_sampler.md
FPGA_PIN_SAMPLER -- requirements
Module: fpga_pin_sampler

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1000: clk cycles per debounce sample tick (>=2).
REQ-002 SHALL have parameter DEBOUNCE_COUNT, default 4: consecutive differing ticks needed to accept a new pin level (1..15).
REQ-003 SHALL have port clk  in  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports pin0..pin15  in  1 each  asynchronous external pins, individually named; pinN maps to bit N of all 16-bit outputs.
REQ-006 SHALL have port ev_valid  out  1  report available.
REQ-007 SHALL have port ev_ready  in  1  consumer accepts report.
REQ-008 SHALL have port ev_state  out  16  debounced pin levels at report time.
REQ-009 SHALL have port ev_changed  out  16  pins whose debounced level changed since last accepted report.
REQ-010 SHALL have port ev_overrun  out  1  sticky: some pin changed twice before being reported.
REQ-011 SHALL have port ev_clear  in  1  synchronous clear of ev_overrun.

Function
REQ-012 Each pin SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A prescaler SHALL count 0..SAMPLE_DIV-1 and wrap to 0, asserting tick for one cycle when its value is SAMPLE_DIV-1.
REQ-014 Per pin, on tick: synced != stable -> cnt+1; synced == stable -> cnt=0; no tick -> cnt held.
REQ-015 When cnt would reach DEBOUNCE_COUNT, stable SHALL take synced and cnt SHALL go to 0 in the same cycle; this cycle raises that pin's change pulse.
REQ-016 A bounce (synced returns to stable) before DEBOUNCE_COUNT ticks SHALL leave stable unchanged and report nothing.
REQ-017 Reporting FSM states: IDLE, REPORT.
REQ-018 IDLE with any change pulse: next cycle ev_valid=1, ev_state=new stable vector, ev_changed=pulse mask, go REPORT.
REQ-019 REPORT: ev_state/ev_changed SHALL be held stable while ev_valid=1 and ev_ready=0; new pulses OR into an internal pending mask.
REQ-020 A pulse on a pin already set in ev_changed or pending SHALL set ev_overrun.
REQ-021 REPORT with ev_ready=1: if (pending | same-cycle pulses) != 0, reload ev_changed with that mask, ev_state with current stable, keep ev_valid=1, clear pending; else ev_valid=0, go IDLE.
REQ-022 Pulses coinciding with acceptance SHALL never be lost (merged per REQ-021).
REQ-023 ev_ready SHALL be ignored while ev_valid=0.
REQ-024 ev_clear=1 SHALL clear ev_overrun; a simultaneous set wins.
REQ-025 Latency pin edge -> ev_valid: 2 sync cycles + DEBOUNCE_COUNT ticks + 1 cycle.

Reset
REQ-026 rst_n low SHALL asynchronously clear synchronizers, prescaler, all cnt, stable, pending, ev_state, ev_changed, ev_valid, ev_overrun; FSM to IDLE.
REQ-027 After release, pins already high SHALL be reported as changes via normal debounce.
REQ-028 Reset asserted mid-REPORT SHALL drop the pending report with no glitch on ev_valid beyond going low.

Structure
REQ-029 Shared package: NUM_PINS=16, FSM state encoding, cnt width constant (4 bits).
REQ-030 One sub-module pin_debounce (synchronizer + cnt + stable + pulse), instantiated 16 times; FSM, prescaler, output regs in top.

Verification (SAMPLE_DIV=4, DEBOUNCE_COUNT=3)
REQ-031 pin3 0->1 held, ev_ready=1 -> one report ev_state=0x0008, ev_changed=0x0008 within 2+12+1 cycles (+prescaler phase).
REQ-032 pin5 high for 1 tick then low -> no ev_valid ever, ev_state unchanged.
REQ-033 pin0 and pin15 rise together, ev_ready=0 -> ev_changed=0x8001 held; raise ev_ready -> one accept, ev_valid drops.
REQ-034 ev_ready=0, pin2 rises, then pin4 rises -> first report 0x0004; on accept immediately 0x0010 with ev_valid continuous.
REQ-035 ev_ready=0, pin7 rises then falls (debounced) -> ev_overrun=1; ev_clear -> 0.
REQ-036 rst_n low mid-REPORT -> all outputs 0 asynchronously; after release pins held high reported as 0xFFFF if all high.
